// File: rtl/uart_pkg.sv
// Shared types and elaboration-time helpers for the buffered UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

  localparam int unsigned DataBits = 8;

  // Round-to-nearest clock cycles per serial bit.
  function automatic int unsigned calc_divisor(input int unsigned freq, input int unsigned bps);
    return (freq + bps / 2) / bps;
  endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Byte write port of the buffered UART: producer drives data/strobe, transmitter reports full.
interface uart_tx_buffered_if;

  logic [7:0] transmit_data;
  logic       we;
  logic       busy;

  modport master (
    output transmit_data,
    output we,
    input  busy
  );

  modport slave (
    input  transmit_data,
    input  we,
    output busy
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra pointer MSB to tell full from empty; synchronous active-high reset.
module sync_fifo #(
  parameter int unsigned Width     = 8,
  parameter int unsigned DepthLog2 = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr_en_i,
  input  logic [Width-1:0]     wr_data_i,
  input  logic                 rd_en_i,
  output logic [Width-1:0]     rd_data_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [DepthLog2:0]   level_o
);

  localparam int unsigned Depth = 1 << DepthLog2;

  logic [Width-1:0]   mem_q [Depth];
  logic [DepthLog2:0] wr_ptr_q, wr_ptr_d;
  logic [DepthLog2:0] rd_ptr_q, rd_ptr_d;
  logic               wr_ok, rd_ok;

  assign full_o  = (wr_ptr_q[DepthLog2] != rd_ptr_q[DepthLog2]) &&
                   (wr_ptr_q[DepthLog2-1:0] == rd_ptr_q[DepthLog2-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign level_o = wr_ptr_q - rd_ptr_q;

  // Full is judged on registered pointers, so a same-cycle pop never frees room for a write.
  assign wr_ok = wr_en_i && !full_o;
  assign rd_ok = rd_en_i && !empty_o;

  assign rd_data_o = mem_q[rd_ptr_q[DepthLog2-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_ok) begin
      mem_q[wr_ptr_q[DepthLog2-1:0]] <= wr_data_i;
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter fed from a byte FIFO; frames are sent back-to-back while data is queued.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned FREQUENCY  = 50_000_000,
  parameter int unsigned BPS        = 115_200,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  uart_tx_buffered_if.slave     bus,
  output logic                  serial_out,
  output logic                  idle,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow
);

  localparam int unsigned     Divisor = calc_divisor(FREQUENCY, BPS);
  localparam int unsigned     CntW    = (Divisor > 1) ? $clog2(Divisor) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(Divisor - 1);

  tx_state_e           state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [2:0]          bit_q, bit_d;
  logic [DataBits-1:0] shift_q, shift_d;
  logic                line_q, line_d;
  logic                ne_q;
  logic                ovf_q;

  logic                fifo_full, fifo_empty, pop, bit_end;
  logic [DataBits-1:0] head;

  sync_fifo #(
    .Width     (DataBits),
    .DepthLog2 (DEPTH_LOG2)
  ) u_fifo (
    .clk_i     (clock),
    .rst_i     (reset),
    .wr_en_i   (bus.we),
    .wr_data_i (bus.transmit_data),
    .rd_en_i   (pop),
    .rd_data_o (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (level)
  );

  assign bus.busy   = fifo_full;
  assign serial_out = line_q;
  assign overflow   = ovf_q;
  assign idle       = (state_q == StIdle) && fifo_empty;
  assign bit_end    = (cnt_q == CntMax);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;

    unique case (state_q)
      StIdle: begin
        // ne_q delays the launch by one cycle so a fresh byte is seen queued before it leaves.
        if (ne_q && !fifo_empty) begin
          state_d = StStart;
          pop     = 1'b1;
          shift_d = head;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (bit_end) begin
          cnt_d = '0;
          if (!fifo_empty) begin
            state_d = StStart;
            pop     = 1'b1;
            shift_d = head;
            bit_d   = '0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Line is registered from the next state so it moves on the same edge as the FSM.
    case (state_d)
      StStart: line_d = 1'b0;
      StData:  line_d = shift_d[0];
      default: line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      line_q  <= 1'b1;
      ne_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      line_q  <= line_d;
      ne_q    <= !fifo_empty;
      if (bus.we && fifo_full) begin
        ovf_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: scoreboarded frame decoder on two parameterisations.
module tb_uart_tx_buffered;

  localparam int DA = 434;
  localparam int DB = 3;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic       so_a, idle_a, ovf_a;
  logic       so_b, idle_b, ovf_b;
  logic [4:0] lvl_a, lvl_b;

  uart_tx_buffered_if bus_a ();
  uart_tx_buffered_if bus_b ();

  uart_tx_buffered #(
    .FREQUENCY  (50_000_000),
    .BPS        (115_200),
    .DEPTH_LOG2 (4)
  ) dut_a (
    .clock      (clk),
    .reset      (rst_a),
    .bus        (bus_a),
    .serial_out (so_a),
    .idle       (idle_a),
    .level      (lvl_a),
    .overflow   (ovf_a)
  );

  uart_tx_buffered #(
    .FREQUENCY  (1000),
    .BPS        (300),
    .DEPTH_LOG2 (4)
  ) dut_b (
    .clock      (clk),
    .reset      (rst_b),
    .bus        (bus_b),
    .serial_out (so_b),
    .idle       (idle_b),
    .level      (lvl_b),
    .overflow   (ovf_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         total = 0;
  int         bad   = 0;
  int         fd_a  = 0;
  int         fd_b  = 0;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  int         st_a[$];
  int         st_b[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int st_at(input int which, input int i);
    if (which == 0) return (i < st_a.size()) ? st_a[i] : -1;
    return (i < st_b.size()) ? st_b[i] : -1;
  endfunction

  // Decodes frames on one line, checking first and last cycle of every bit against the queue.
  task automatic mon(input int which);
    bit         act = 0;
    int         t0 = 0;
    int         k, idx, d, sz;
    logic [7:0] b = 8'h00;
    logic       line, r, eb;
    d = (which == 0) ? DA : DB;
    forever begin
      @(negedge clk);
      line = (which == 0) ? so_a : so_b;
      r    = (which == 0) ? rst_a : rst_b;
      if (r) begin
        act = 0;
      end else begin
        if (!act && line === 1'b0) begin
          act = 1;
          t0  = cyc;
          sz  = (which == 0) ? exp_a.size() : exp_b.size();
          check("frame_expected", sz > 0, 1);
          if (which == 0) st_a.push_back(cyc);
          else st_b.push_back(cyc);
          if (sz > 0) b = (which == 0) ? exp_a.pop_front() : exp_b.pop_front();
          else b = 8'h00;
        end
        if (act) begin
          k   = cyc - t0;
          idx = k / d;
          if ((k % d == 0) || (k % d == d - 1)) begin
            eb = (idx == 0) ? 1'b0 : (idx == 9) ? 1'b1 : b[idx-1];
            check($sformatf("dut%0d_bit%0d_of_%02h_k%0d", which, idx, b, k), line, eb);
          end
          if (k == 10 * d - 1) begin
            act = 0;
            if (which == 0) fd_a++;
            else fd_b++;
          end
        end
      end
    end
  endtask

  initial mon(0);
  initial mon(1);

  task automatic wr(input int which, input logic [7:0] d, input bit accept, output int acc);
    if (which == 0) begin
      bus_a.transmit_data = d;
      bus_a.we = 1'b1;
      if (accept) exp_a.push_back(d);
    end else begin
      bus_b.transmit_data = d;
      bus_b.we = 1'b1;
      if (accept) exp_b.push_back(d);
    end
    @(posedge clk);
    #1;
    bus_a.we = 1'b0;
    bus_b.we = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_frames(input int which, input int n, input int limit, input string tag);
    int c = 0;
    while (((which == 0) ? fd_a : fd_b) < n && c < limit) begin
      @(negedge clk);
      c++;
    end
    check(tag, ((which == 0) ? fd_a : fd_b) >= n, 1);
  endtask

  task automatic to_cycle(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  int acc, a0, c2, s0;

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.we = 1'b0;
    bus_a.transmit_data = 8'h00;
    bus_b.we = 1'b0;
    bus_b.transmit_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);
    check("rst_serial", so_a, 1);
    check("rst_busy", bus_a.busy, 0);
    check("rst_idle", idle_a, 1);
    check("rst_level", lvl_a, 0);
    check("rst_overflow", ovf_a, 0);
    check("rst_b_serial", so_b, 1);

    // Single byte from idle
    wr(0, 8'h41, 1, acc);
    @(negedge clk);
    check("single_level", lvl_a, 1);
    check("single_not_idle", idle_a, 0);
    wait_frames(0, 1, 5000, "single_frame_done");
    check("single_start_latency", st_at(0, 0), acc + 2);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("single_idle_after", idle_a, 1);
    check("single_line_after", so_a, 1);
    check("single_level_after", lvl_a, 0);

    // Burst of three on consecutive cycles
    st_a.delete();
    fd_a = 0;
    wr(0, 8'h0D, 1, acc);
    @(negedge clk);
    check("burst_level_1", lvl_a, 1);
    wr(0, 8'h0A, 1, acc);
    @(negedge clk);
    check("burst_level_2", lvl_a, 2);
    wr(0, 8'h35, 1, c2);
    @(negedge clk);
    check("burst_level_3", lvl_a, 2);
    to_cycle(c2 + 10 * DA);
    @(negedge clk);
    check("burst_level_pop2", lvl_a, 1);
    to_cycle(c2 + 20 * DA);
    @(negedge clk);
    check("burst_level_pop3", lvl_a, 0);
    wait_frames(0, 3, 14000, "burst_frames_done");
    check("burst_first_start", st_at(0, 0), c2);
    check("burst_gap_1", st_at(0, 1) - st_at(0, 0), 10 * DA);
    check("burst_gap_2", st_at(0, 2) - st_at(0, 1), 10 * DA);

    // Reset during data bit 4, with a write coincident with reset
    st_a.delete();
    fd_a = 0;
    wr(0, 8'h3C, 1, a0);
    wr(0, 8'h11, 1, acc);
    wr(0, 8'h22, 1, acc);
    to_cycle(a0 + 2 + 5 * DA + 100);
    rst_a = 1'b1;
    bus_a.transmit_data = 8'h99;
    bus_a.we = 1'b1;
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    bus_a.we = 1'b0;
    exp_a.delete();
    @(negedge clk);
    check("midrst_serial", so_a, 1);
    check("midrst_level", lvl_a, 0);
    check("midrst_idle", idle_a, 1);
    check("midrst_overflow", ovf_a, 0);
    repeat (50) @(negedge clk);
    check("midrst_no_frame", fd_a, 0);
    check("midrst_line_quiet", so_a, 1);
    st_a.delete();
    wr(0, 8'h55, 1, acc);
    wait_frames(0, 1, 5000, "midrst_55_done");
    check("midrst_55_latency", st_at(0, 0), acc + 2);

    // Divisor rounding: 1000 Hz / 300 bps -> 3-cycle bits
    wr(1, 8'hA5, 1, acc);
    wait_frames(1, 1, 100, "div3_frame_done");
    check("div3_start_latency", st_at(1, 0), acc + 2);

    // Fill to full, then one rejected write
    st_b.delete();
    fd_b = 0;
    for (int i = 0; i < 17; i++) wr(1, 8'(i * 13 + 1), 1, acc);
    @(negedge clk);
    check("full_level", lvl_b, 16);
    check("full_busy", bus_b.busy, 1);
    wr(1, 8'hEE, 0, acc);
    @(negedge clk);
    check("full_overflow", ovf_b, 1);
    check("full_level_kept", lvl_b, 16);
    wait_frames(1, 17, 17 * 10 * DB + 100, "full_frames_done");
    @(posedge clk);
    #1;
    @(negedge clk);
    check("full_idle_after", idle_b, 1);

    // Write while full on the pop edge
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    exp_b.delete();
    st_b.delete();
    fd_b = 0;
    @(negedge clk);
    check("popfull_ovf_cleared", ovf_b, 0);
    wr(1, 8'h02, 1, a0);
    for (int i = 1; i < 17; i++) wr(1, 8'(i * 5 + 2), 1, acc);
    s0 = a0 + 2;
    to_cycle(s0 + 10 * DB - 1);
    bus_b.transmit_data = 8'hEE;
    bus_b.we = 1'b1;
    @(negedge clk);
    check("popfull_busy_before", bus_b.busy, 1);
    check("popfull_level_before", lvl_b, 16);
    @(posedge clk);
    #1;
    bus_b.we = 1'b0;
    @(negedge clk);
    check("popfull_level_after", lvl_b, 15);
    check("popfull_overflow", ovf_b, 1);
    check("popfull_busy_after", bus_b.busy, 0);
    wait_frames(1, 17, 17 * 10 * DB + 100, "popfull_frames_done");
    check("popfull_first_start", st_at(1, 0), s0);
    check("popfull_second_start", st_at(1, 1), s0 + 10 * DB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
